// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
//   Shared definitions for the FT245-style USB FIFO blocks.
//   - usb_tx_state_e : 3-bit state encoding of usb_status_transmitter,
//                      also exported on state_out for the LEDs.
//   - USB_TX_HEADER  : first byte of every status frame.
//   - USB_TX_FRAME_LEN_CSUM / USB_TX_FRAME_LEN_PLAIN : frame lengths with
//                      and without the trailing checksum byte.
//   - usb_tx_checksum: XOR of header and both payload bytes.
// ---------------------------------------------------------------------------
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_WAIT_TXE = 3'd2,
        ST_SETUP    = 3'd3,
        ST_STROBE   = 3'd4,
        ST_RECOVER  = 3'd5,
        ST_DONE     = 3'd6,
        ST_ABORT    = 3'd7
    } usb_tx_state_e;

    localparam logic [7:0] USB_TX_HEADER          = 8'hA5;
    localparam int         USB_TX_FRAME_LEN_CSUM  = 4;
    localparam int         USB_TX_FRAME_LEN_PLAIN = 3;

    function automatic logic [7:0] usb_tx_checksum(input logic [15:0] payload);
        return USB_TX_HEADER ^ payload[15:8] ^ payload[7:0];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level (txe_n_raw,
//   rxf_n_raw). A change on d appears on q two clock edges later.
//   Ports:
//     clk     in  system clock
//     reset_n in  asynchronous active-low reset (both flops go to RESET_VAL)
//     d       in  asynchronous input level
//     q       out synchronized level
//   Parameter RESET_VAL: value held while in reset; 1 suits active-low
//   FIFO flags, so "not ready" is assumed until the pin has been sampled.
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so the second flop takes meta_q's pre-edge value.
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/usb_status_transmitter.sv
// ---------------------------------------------------------------------------
// usb_status_transmitter
//   Sends a short status frame (A5, payload[15:8], payload[7:0], optional
//   checksum) to the host through the FT245-style FIFO write path. It asks
//   for the shared data bus, waits for FIFO space on txe_n for every byte,
//   drives the byte, pulses wr_n low and lets the bus recover.
//
//   Build option: define USB_TX_CHECKSUM_EN for a 4-byte frame whose last
//   byte is A5 ^ payload[15:8] ^ payload[7:0]; otherwise the frame is
//   3 bytes and no checksum logic exists.
//
//   Ports:
//     clk             in   system clock (50 MHz)
//     reset_n         in   asynchronous active-low reset
//     send_req        in   one-cycle request; accepted only in IDLE
//     payload[15:0]   in   captured with an accepted send_req
//     txe_n_raw       in   FIFO space flag, active low, asynchronous
//     bus_grant       in   shared bus granted (looked at only in ARB)
//     bus_request     out  bus requested / held for the frame
//     data_bus_out    out  byte being written (00 when not driving)
//     data_out_enable out  drive enable for the shared data bus
//     wr_n            out  FIFO write strobe, active low
//     busy            out  frame in progress
//     done            out  one-cycle pulse on frame completion
//     timeout         out  one-cycle pulse when txe_n wait expires
//     state_out[2:0]  out  current state for the LEDs
//
//   All outputs are decoded from the state register alone, so asserting
//   reset_n drops them to their idle values in the same cycle and a strobe
//   in flight ends immediately.
// ---------------------------------------------------------------------------
module usb_status_transmitter
    import usb_pkg::*;
#(
    parameter int SETUP_CYCLES    = 2,
    parameter int WR_LOW_CYCLES   = 3,
    parameter int RECOVERY_CYCLES = 4,
    parameter int TXE_TIMEOUT     = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        send_req,
    input  logic [15:0] payload,
    input  logic        txe_n_raw,
    input  logic        bus_grant,
    output logic        bus_request,
    output logic [7:0]  data_bus_out,
    output logic        data_out_enable,
    output logic        wr_n,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [2:0]  state_out
);

`ifdef USB_TX_CHECKSUM_EN
    localparam int FRAME_LEN = USB_TX_FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN = USB_TX_FRAME_LEN_PLAIN;
`endif

    // One counter serves every timed state: it is cleared on each state
    // change, so it is sized for the longest interval.
    localparam int MAX_A   = (SETUP_CYCLES > WR_LOW_CYCLES) ? SETUP_CYCLES : WR_LOW_CYCLES;
    localparam int MAX_B   = (MAX_A > RECOVERY_CYCLES) ? MAX_A : RECOVERY_CYCLES;
    localparam int CNT_MAX = (MAX_B > TXE_TIMEOUT) ? MAX_B : TXE_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOW_LAST  = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVERY_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TXE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [1:0]       LAST_IDX     = 2'(FRAME_LEN - 1);

    usb_tx_state_e    state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [1:0]       idx_d, idx_q;
    logic [15:0]      payload_d, payload_q;
    logic             txe_n_sync;
    logic [7:0]       cur_byte;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_txe_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (txe_n_raw),
        .q       (txe_n_sync)
    );

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        payload_d = payload_q;

        case (state_q)
            ST_IDLE: begin
                if (send_req) begin
                    payload_d = payload;
                    idx_d     = '0;
                    state_d   = ST_ARB;
                end
            end
            ST_ARB: begin
                if (bus_grant) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_TXE;
                end
            end
            ST_WAIT_TXE: begin
                // FIFO space wins over an expiry landing in the same cycle.
                if (!txe_n_sync) begin
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == WR_LOW_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == RECOVER_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_WAIT_TXE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE,
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            payload_q <= payload_d;
        end
    end

    // ---------------- frame byte select ----------------
    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = USB_TX_HEADER;
            2'd1:    cur_byte = payload_q[15:8];
            2'd2:    cur_byte = payload_q[7:0];
`ifdef USB_TX_CHECKSUM_EN
            2'd3:    cur_byte = usb_tx_checksum(payload_q);
`endif
            default: cur_byte = USB_TX_HEADER;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        bus_request     = 1'b0;
        busy            = 1'b0;
        data_out_enable = 1'b0;
        wr_n            = 1'b1;
        done            = 1'b0;
        timeout         = 1'b0;

        case (state_q)
            ST_ARB, ST_WAIT_TXE: begin
                bus_request = 1'b1;
                busy        = 1'b1;
            end
            ST_SETUP, ST_RECOVER: begin
                bus_request     = 1'b1;
                busy            = 1'b1;
                data_out_enable = 1'b1;
            end
            ST_STROBE: begin
                bus_request     = 1'b1;
                busy            = 1'b1;
                data_out_enable = 1'b1;
                wr_n            = 1'b0;
            end
            ST_DONE:  done    = 1'b1;
            ST_ABORT: timeout = 1'b1;
            default: ;
        endcase

        // The byte is held from SETUP through RECOVER; the bus reads 00 otherwise.
        data_bus_out = data_out_enable ? cur_byte : 8'h00;
        state_out    = state_q;
    end

endmodule
